// File: rtl/greenhouse_sensor_qualifier.sv
// Synchronises and debounces six greenhouse sensor contacts into the qualified vector S,
// with change strobe, saturating event count and warm-up flag. Optional: GREENHOUSE_GAS_LATCH_EN.
module greenhouse_sensor_qualifier #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] raw_in,
  input  logic       gas_ack,
  output logic [5:0] S,
  output logic       s_valid,
  output logic       change_pulse,
  output logic [7:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int               WARM    = DEBOUNCE_CYCLES + 1;
  localparam int               WW      = $clog2(WARM + 1);

  logic [5:0]       sync1_q, sync1_d;
  logic [5:0]       sync2_q, sync2_d;
  logic [5:0]       s_q, s_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];
  logic             change_pulse_q, change_pulse_d;
  logic [7:0]       evt_q, evt_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic             s_valid_q, s_valid_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    s_d     = s_q;
    for (int unsigned i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != s_q[i]) begin
        if (cnt_q[i] == CNT_LIM) s_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
`ifdef GREENHOUSE_GAS_LATCH_EN
    // Once latched, gas ignores the debouncer and only an ack with the contact low releases it.
    if (s_q[5]) begin
      cnt_d[5] = '0;
      s_d[5]   = !(gas_ack && !sync2_q[5]);
    end
`endif
    change_pulse_d = (s_d != s_q);
    evt_d          = (change_pulse_d && (evt_q != 8'hFF)) ? evt_q + 8'd1 : evt_q;
    warm_d         = s_valid_q ? warm_q : warm_q + 1'b1;
    s_valid_d      = s_valid_q | (warm_q == WW'(WARM));
  end

`ifndef GREENHOUSE_GAS_LATCH_EN
  logic unused_gas_ack;
  assign unused_gas_ack = gas_ack;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      s_q            <= '0;
      for (int unsigned i = 0; i < 6; i++) cnt_q[i] <= '0;
      change_pulse_q <= 1'b0;
      evt_q          <= '0;
      warm_q         <= '0;
      s_valid_q      <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      s_q            <= s_d;
      for (int unsigned i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
      change_pulse_q <= change_pulse_d;
      evt_q          <= evt_d;
      warm_q         <= warm_d;
      s_valid_q      <= s_valid_d;
    end
  end

  assign S            = s_q;
  assign s_valid      = s_valid_q;
  assign change_pulse = change_pulse_q;
  assign evt_cnt      = evt_q;

endmodule

// File: tb/tb_greenhouse_sensor_qualifier.sv
// Directed bench for greenhouse_sensor_qualifier at DEBOUNCE_CYCLES=4.
module tb_greenhouse_sensor_qualifier;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] raw_in = '0;
  logic       gas_ack = 1'b0;
  logic [5:0] S;
  logic       s_valid;
  logic       change_pulse;
  logic [7:0] evt_cnt;

  int checks = 0;
  int errors = 0;

  greenhouse_sensor_qualifier #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .gas_ack(gas_ack),
    .S(S), .s_valid(s_valid), .change_pulse(change_pulse), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] raw;
    logic       ack;
    int         steps;
    logic [5:0] s;
    logic       pulse;
    logic [7:0] evt;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [5:0] r, input logic a, input int n,
                     input logic [5:0] s, input logic p, input logic [7:0] e);
    vec_t v;
    v.name = nm; v.raw = r; v.ack = a; v.steps = n; v.s = s; v.pulse = p; v.evt = e;
    vecs.push_back(v);
  endtask

  initial begin
    int pulses;

    add("s1_pre",     6'b000010, 1'b0, 5, 6'b000000, 1'b0, 8'd0);
    add("s1_rise",    6'b000010, 1'b0, 1, 6'b000010, 1'b1, 8'd1);
    add("s1_hold",    6'b000010, 1'b0, 1, 6'b000010, 1'b0, 8'd1);
    add("glitch_hi",  6'b000011, 1'b0, 3, 6'b000010, 1'b0, 8'd1);
    add("glitch_lo",  6'b000010, 1'b0, 6, 6'b000010, 1'b0, 8'd1);
    add("dual_pre",   6'b001110, 1'b0, 5, 6'b000010, 1'b0, 8'd1);
    add("dual_rise",  6'b001110, 1'b0, 1, 6'b001110, 1'b1, 8'd2);
    add("gas_pre",    6'b101110, 1'b0, 5, 6'b001110, 1'b0, 8'd2);
    add("gas_rise",   6'b101110, 1'b0, 1, 6'b101110, 1'b1, 8'd3);
    add("gas_ack_hi", 6'b101110, 1'b1, 4, 6'b101110, 1'b0, 8'd3);
`ifdef GREENHOUSE_GAS_LATCH_EN
    add("gas_latched", 6'b001110, 1'b0, 6, 6'b101110, 1'b0, 8'd3);
    add("gas_ack_lo",  6'b001110, 1'b1, 1, 6'b001110, 1'b1, 8'd4);
    add("gas_clear",   6'b001110, 1'b0, 1, 6'b001110, 1'b0, 8'd4);
`else
    add("gas_fall_pre", 6'b001110, 1'b0, 5, 6'b101110, 1'b0, 8'd3);
    add("gas_fall",     6'b001110, 1'b0, 1, 6'b001110, 1'b1, 8'd4);
    add("gas_ack_lo",   6'b001110, 1'b1, 1, 6'b001110, 1'b0, 8'd4);
`endif

    // Reset state and warm-up
    step(2);
    chk("rst_S", S, 6'd0);
    chk("rst_pulse", change_pulse, 1'b0);
    chk("rst_evt", evt_cnt, 8'd0);
    chk("rst_valid", s_valid, 1'b0);
    reset = 1'b0;
    step(5);
    chk("warm_5", s_valid, 1'b0);
    step(1);
    chk("warm_6", s_valid, 1'b1);
    chk("warm_S", S, 6'd0);
    step(3);
    chk("warm_sticky", s_valid, 1'b1);

    foreach (vecs[i]) begin
      raw_in  = vecs[i].raw;
      gas_ack = vecs[i].ack;
      step(vecs[i].steps);
      chk({vecs[i].name, "_S"}, S, vecs[i].s);
      chk({vecs[i].name, "_pulse"}, change_pulse, vecs[i].pulse);
      chk({vecs[i].name, "_evt"}, evt_cnt, vecs[i].evt);
    end
    gas_ack = 1'b0;

    // 300 qualified toggles of FLUSH: evt_cnt saturates
    pulses = 0;
    for (int t = 0; t < 300; t++) begin
      raw_in[4] = ~raw_in[4];
      for (int k = 0; k < 6; k++) begin
        step(1);
        if (change_pulse === 1'b1) pulses++;
      end
    end
    chk("toggle_pulses", pulses, 300);
    chk("toggle_S", S, 6'b001110);
    chk("sat_evt", evt_cnt, 8'hFF);

    // Reset in the middle of a debounce
    raw_in[4] = 1'b1;
    step(3);
    reset = 1'b1;
    #1;
    chk("mid_rst_S", S, 6'd0);
    chk("mid_rst_evt", evt_cnt, 8'd0);
    chk("mid_rst_pulse", change_pulse, 1'b0);
    chk("mid_rst_valid", s_valid, 1'b0);
    step(2);
    reset = 1'b0;
    step(5);
    chk("post_rst_pre", S, 6'd0);
    step(1);
    chk("post_rst_S", S, 6'b011110);
    chk("post_rst_pulse", change_pulse, 1'b1);
    chk("post_rst_evt", evt_cnt, 8'd1);
    chk("post_rst_valid", s_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
